iter_divider: RTL

Iterative 32-bit integer divider paired with the Wallace-tree multiplier in the EXE stage. It accepts one signed or unsigned division per handshake, runs a radix-2 restoring loop over 32 cycles, and returns quotient and remainder through a valid/ready output handshake. It shares `mul_clk` and `resetn` with the multiplier and supports a flush input for pipeline cancellation.

---
 rtl/iter_divider.sv | 74 +++++++
 1 files changed

// File: rtl/iter_divider.sv
// iter_divider: radix-2 restoring 32-step signed/unsigned divider with valid/ready handshakes and flush
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, ay;
  logic [WIDTH:0] trial;
  logic q_neg, r_neg, dbz_r, accept;
  assign accept = state == IDLE && in_valid && !cancel;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign trial = {rem, dvd[WIDTH-1]} - {1'b0, ay};
  // state register; reset wins over everything
  always_ff @(posedge mul_clk)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // next state; cancel overrides accept and the output handshake
  always_comb begin
    state_n = cancel ? IDLE :
              accept ? CALC :
              (state == CALC && cnt == CW'(WIDTH - 1)) ? FIX :
              state == FIX ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  // operand capture, one restoring step per CALC cycle, sign fix into the output registers
  always_ff @(posedge mul_clk)
    if (!resetn) begin
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      ay <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dbz_r <= 1'b0;
      q <= '0;
      r <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      rem <= '0;
      dvd <= (div_signed && x[WIDTH-1]) ? -x : x;
      ay <= (div_signed && y[WIDTH-1]) ? -y : y;
      q_neg <= div_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
      r_neg <= div_signed && x[WIDTH-1];
      dbz_r <= y == '0;
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      rem <= trial[WIDTH] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : trial[WIDTH-1:0];
      dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
    end else if (state == FIX) begin
      // with a zero divisor every step succeeds: dvd is all ones and rem is |x|,
      // so re-applying the dividend sign restores the original x
      q <= (q_neg && !dbz_r) ? -dvd : dvd;
      r <= r_neg ? -rem : rem;
      dbz <= dbz_r;
    end
endmodule
